// File: rtl/key_scan.sv
// 4x4 keypad scanner: one active-low row per slot, 2-flop column sync, debounced press/release.
// Press accepted DEB_CNT matching cycles after a one-hot slot-end sample; release needs DEB_CNT idle cycles.
module key_scan #(
    parameter int SCAN_DIV = 50000,
    parameter int DEB_CNT  = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col_in,
    output logic [3:0] row_scan,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CNT - 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [1:0]  r, r_nx;
    logic [1:0]  c, c_nx;
    logic [SW-1:0] slot, slot_nx;
    logic [DW-1:0] cnt, cnt_nx;
    logic [3:0]  col_m, col_s;
    logic [3:0]  col_lat, col_lat_nx;
    logic [3:0]  code_nx;
    logic        valid_nx, down_nx;
    logic        hit;
    logic [1:0]  hit_idx;

    function automatic logic [3:0] row_dec(input logic [1:0] idx);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << idx);
    endfunction

    // Only a single low column identifies a key; idle and ghosting patterns are skipped.
    always_comb begin
        hit     = 1'b0;
        hit_idx = 2'd0;
        case (col_s)
            4'b1110: begin hit = 1'b1; hit_idx = 2'd0; end
            4'b1101: begin hit = 1'b1; hit_idx = 2'd1; end
            4'b1011: begin hit = 1'b1; hit_idx = 2'd2; end
            4'b0111: begin hit = 1'b1; hit_idx = 2'd3; end
            default: begin hit = 1'b0; hit_idx = 2'd0; end
        endcase
    end

    always_comb begin
        state_nx   = state;
        r_nx       = r;
        c_nx       = c;
        slot_nx    = slot;
        cnt_nx     = cnt;
        col_lat_nx = col_lat;
        code_nx    = key_code;
        valid_nx   = 1'b0;
        down_nx    = key_down;
        case (state)
            SCAN: begin
                if (slot == SLOT_LAST) begin
                    slot_nx = '0;
                    if (hit) begin
                        col_lat_nx = col_s;
                        c_nx       = hit_idx;
                        cnt_nx     = '0;
                        state_nx   = DEBOUNCE;
                    end else begin
                        r_nx = r + 2'd1;
                    end
                end else begin
                    slot_nx = slot + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (col_s == col_lat) begin
                    if (cnt == DEB_LAST) begin
                        state_nx = PRESSED;
                        code_nx  = {r, c};
                        valid_nx = 1'b1;
                        down_nx  = 1'b1;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end else begin
                    state_nx = SCAN;
                    r_nx     = r + 2'd1;
                    slot_nx  = '0;
                end
            end
            PRESSED: begin
                // Release counter reuses cnt; any non-idle column restarts it.
                if (col_s == 4'hF) begin
                    if (cnt == DEB_LAST) begin
                        state_nx = SCAN;
                        down_nx  = 1'b0;
                        r_nx     = r + 2'd1;
                        slot_nx  = '0;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end else begin
                    cnt_nx = '0;
                end
            end
            default: begin
                state_nx = SCAN;
                r_nx     = 2'd0;
                slot_nx  = '0;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= SCAN;
            r         <= 2'd0;
            c         <= 2'd0;
            slot      <= '0;
            cnt       <= '0;
            col_m     <= 4'hF;
            col_s     <= 4'hF;
            col_lat   <= 4'hF;
            row_scan  <= 4'b1110;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
        end else begin
            state     <= state_nx;
            r         <= r_nx;
            c         <= c_nx;
            slot      <= slot_nx;
            cnt       <= cnt_nx;
            col_m     <= col_in;
            col_s     <= col_m;
            col_lat   <= col_lat_nx;
            row_scan  <= row_dec(r_nx);
            key_code  <= code_nx;
            key_valid <= valid_nx;
            key_down  <= down_nx;
        end
    end

endmodule

// File: tb/tb_key_scan.sv
// Bench for key_scan: keypad model reacting to row_scan, expected-press queue drained by a key_valid monitor.
module tb_key_scan;
    localparam int SCAN_DIV = 8;
    localparam int DEB_CNT  = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] col_in;
    logic [3:0] row_scan;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;

    logic       pressed = 1'b0;
    int         prow = 0;
    logic [3:0] pmask = 4'h0;

    int n_total = 0;
    int n_pass  = 0;
    logic [3:0] exp_q[$];

    key_scan #(.SCAN_DIV(SCAN_DIV), .DEB_CNT(DEB_CNT)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .col_in(col_in),
        .row_scan(row_scan),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_down(key_down)
    );

    // Keypad: held switches pull their columns low only while their row is driven.
    assign col_in = (pressed && row_scan[prow] == 1'b0) ? ~pmask : 4'hF;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [3:0] row_pat(input int r);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << r);
    endfunction

    function automatic logic [3:0] col_bit(input int c);
        logic [3:0] one;
        one = 4'b0001;
        return one << c;
    endfunction

    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_key_valid", key_valid, 0);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                check("key_code_on_valid", key_code, e);
                check("key_down_on_valid", key_down, 1);
            end
        end
    end

    task automatic wait_down(input logic level, input int budget);
        for (int i = 0; i < budget && key_down !== level; i++) @(negedge clk);
    endtask

    task automatic long_press(input int r, input int c, input int extra);
        @(posedge clk);
        #1;
        prow = r; pmask = col_bit(c); pressed = 1'b1;
        exp_q.push_back({2'(r), 2'(c)});
        wait_down(1'b1, 200);
        check("press_accepted", key_down, 1);
        check("press_code_held", key_code, {2'(r), 2'(c)});
        repeat (extra) @(posedge clk);
        @(posedge clk);
        #1 pressed = 1'b0;
        // Two sync stages, then DEB_CNT idle cycles: key_down falls on the 18th edge.
        repeat (17) @(posedge clk);
        @(negedge clk) check("release_not_early", key_down, 1);
        @(negedge clk) check("release_done", key_down, 0);
        check("scan_resumes_next_row", row_scan, row_pat((r + 1) % 4));
    endtask

    task automatic bounce(input int r, input int c, input int toggles);
        @(posedge clk);
        #1;
        prow = r; pmask = col_bit(c);
        for (int i = 0; i < toggles; i++) begin
            pressed = ~pressed;
            repeat (3) @(posedge clk);
            #1;
        end
        pressed = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_row_scan", row_scan, 4'b1110);
        check("reset_key_code", key_code, 4'h0);
        check("reset_key_valid", key_valid, 0);
        check("reset_key_down", key_down, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            check("idle_scan_row", row_scan, row_pat((k / SCAN_DIV) % 4));
        end

        long_press(2, 1, 20);

        // Release glitch: one low cycle after 10 idle cycles must restart the release count.
        @(posedge clk);
        #1;
        prow = 1; pmask = col_bit(3); pressed = 1'b1;
        exp_q.push_back(4'b0111);
        wait_down(1'b1, 200);
        check("glitch_press_accepted", key_down, 1);
        @(posedge clk);
        #1 pressed = 1'b0;
        repeat (10) @(posedge clk);
        #1 pressed = 1'b1;
        @(posedge clk);
        #1 pressed = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk) check("glitch_down_held", key_down, 1);
        wait_down(1'b0, 40);
        check("glitch_release_done", key_down, 0);

        @(posedge clk);
        #1;
        prow = 0; pmask = 4'b0011; pressed = 1'b1;
        repeat (80) @(posedge clk);
        @(negedge clk) check("multi_key_ignored", key_down, 0);
        pressed = 1'b0;
        repeat (20) @(posedge clk);

        bounce(0, 0, 20);
        @(negedge clk) check("bounce_no_down", key_down, 0);
        repeat (20) @(posedge clk);

        for (int it = 0; it < 20; it++) begin
            int kind;
            int r;
            int c;
            int n;
            kind = $urandom_range(0, 3);
            r = $urandom_range(0, 3);
            c = $urandom_range(0, 3);
            case (kind)
                0: long_press(r, c, $urandom_range(0, 20));
                1: begin
                    n = $urandom_range(1, 10);
                    @(posedge clk);
                    #1;
                    prow = r; pmask = col_bit(c); pressed = 1'b1;
                    repeat (n) @(posedge clk);
                    #1 pressed = 1'b0;
                    @(negedge clk) check("short_press_no_down", key_down, 0);
                end
                2: begin
                    bounce(r, c, $urandom_range(4, 20));
                    @(negedge clk) check("rand_bounce_no_down", key_down, 0);
                end
                default: begin
                    n = (c + 1 + $urandom_range(0, 2)) % 4;
                    @(posedge clk);
                    #1;
                    prow = r; pmask = col_bit(c) | col_bit(n); pressed = 1'b1;
                    repeat (60) @(posedge clk);
                    @(negedge clk) check("rand_multi_no_down", key_down, 0);
                    pressed = 1'b0;
                end
            endcase
            repeat ($urandom_range(10, 30)) @(posedge clk);
        end

        // Reset while a key is held must drop everything without a pulse.
        @(posedge clk);
        #1;
        prow = 3; pmask = col_bit(2); pressed = 1'b1;
        exp_q.push_back(4'b1110);
        wait_down(1'b1, 200);
        check("pre_reset_press", key_down, 1);
        @(posedge clk);
        #1 begin rst_n = 1'b0; pressed = 1'b0; end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("mid_reset_key_down", key_down, 0);
        check("mid_reset_key_code", key_code, 4'h0);
        check("mid_reset_row_scan", row_scan, 4'b1110);
        check("mid_reset_key_valid", key_valid, 0);
        repeat (40) @(posedge clk);
        @(negedge clk) check("post_reset_idle", key_down, 0);

        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/key_scan.md
KEY_SCAN -- requirements
Module: key_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, meaning clock cycles each keypad row is driven; legal values 4 and above.
REQ-002 SHALL have parameter DEB_CNT, default 500000, meaning consecutive stable cycles required for a press or release; legal range 2 to 2^20-1.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port col_in, input, 4 bits: keypad column lines, active-low, asynchronous to clk.
REQ-006 SHALL have port row_scan, output, 4 bits: keypad row drive, active-low, one row low at a time.
REQ-007 SHALL have port key_code, output, 4 bits: code of the last accepted key.
REQ-008 SHALL have port key_valid, output, 1 bit: one-cycle pulse on each accepted press.
REQ-009 SHALL have port key_down, output, 1 bit: high while an accepted key remains held.

Function
REQ-010 SHALL pass col_in through a 2-flop synchronizer; all decisions SHALL use the synchronized value (col_s).
REQ-011 SHALL drive row_scan from row index r: r=0 gives 1110, r=1 gives 1101, r=2 gives 1011, r=3 gives 0111; all outputs registered.
REQ-012 SHALL implement a 3-state FSM: SCAN, DEBOUNCE, PRESSED.
REQ-013 In SCAN, SHALL run a slot counter 0..SCAN_DIV-1 and evaluate col_s only when the counter is SCAN_DIV-1.
REQ-014 At SCAN slot end with col_s not one-hot-low, including 1111 and any multi-low pattern, SHALL advance r, wrap 3 to 0, and clear the slot counter.
REQ-015 At SCAN slot end with col_s one-hot-low, SHALL latch col_s and column index c (bit position of the 0), hold r, clear the debounce counter, and enter DEBOUNCE.
REQ-016 In DEBOUNCE, SHALL increment the debounce counter each cycle col_s equals the latched value.
REQ-017 In DEBOUNCE, any mismatch SHALL return to SCAN with r advanced, slot counter 0, and no output change.
REQ-018 When the debounce counter equals DEB_CNT-1 with col_s matching, SHALL enter PRESSED on the next edge.
REQ-019 On that edge, SHALL set key_code to {r[1:0], c[1:0]}, pulse key_valid high for exactly one cycle, and set key_down high.
REQ-020 In PRESSED, SHALL hold r and count consecutive cycles with col_s equal to 1111; any other value SHALL clear the count, including a different key pressed in the same row.
REQ-021 When the release count reaches DEB_CNT-1, SHALL clear key_down and return to SCAN with r advanced and slot counter 0.
REQ-022 SHALL retain key_code until the next accepted press.
REQ-023 SHALL never assert key_valid outside the DEBOUNCE-to-PRESSED transition.
REQ-024 SHALL size counters to hold SCAN_DIV-1 and DEB_CNT-1 without overflow.

Reset
REQ-025 While rst_n is low at a clk edge: state SCAN, r=0, row_scan=1110, slot and debounce counters 0, synchronizer flops 1111, key_code=0000, key_valid=0, key_down=0.
REQ-026 Reset asserted mid-DEBOUNCE or mid-PRESSED SHALL abort without a key_valid pulse; key_down SHALL be 0 the cycle after reset.

Verification (SCAN_DIV=8, DEB_CNT=16)
REQ-027 No key: row_scan cycles 1110, 1101, 1011, 0111, 1110, each held 8 cycles; key_valid never rises.
REQ-028 Key row 2 / col 1 (col_in=1101 while row_scan=1011), held 40 cycles: one key_valid pulse, key_code=1001, key_down=1; after release and 16 stable cycles, key_down=0 and scan resumes at 0111.
REQ-029 Bounce: col_in toggles 1110/1111 every 3 cycles during DEBOUNCE: no key_valid; scan resumes at the next row.
REQ-030 Multi-key: col_in=1100 on row 0: ignored, no key_valid; scan continues.
REQ-031 Glitch in release: col_in returns to 1111 for 10 cycles, low 1 cycle, then 1111: key_down stays 1 until 16 consecutive 1111 cycles.
REQ-032 rst_n low for 1 cycle during PRESSED: next cycle key_down=0, key_code=0000, row_scan=1110, no key_valid.
